multdiv_sequencer: RTL and testbench

Multicycle signed 32-bit multiply/divide controller for the processor's multdiv path. It owns no adder. Each iteration it drives operands onto the shared 32-bit carry-lookahead adder and consumes the sum and carry-out. Uses the standard multdiv handshake: a one-cycle ctrl pulse starts an operation, and a one-cycle result-ready pulse ends it.

---
 rtl/multdiv_sequencer_if.sv | 37 +++
 rtl/multdiv_sequencer.sv | 176 +++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Purpose: bundles the multdiv start/result handshake and the shared-adder operand/sum path.
// Latency: none, wiring only.
// Backpressure: none; starts are single-cycle pulses and completion is a single-cycle pulse.
interface multdiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_en;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    // Processor side: issues starts, owns the shared adder, consumes results.
    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output add_sum, add_cout,
        input  add_a, add_b, add_cin, add_en,
        input  data_result, data_exception, data_resultRDY, busy
    );

    // Sequencer side.
    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  add_sum, add_cout,
        output add_a, add_b, add_cin, add_en,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Purpose: signed multiply (radix-2 Booth) / divide (restoring) sequencer driving a shared external adder.
// Latency: RDY 33 cycles after start edge for MULT, 34 for DIV, 1 for divide-by-zero.
// Backpressure: none; a new start at any time aborts the current operation without a RDY pulse.
module multdiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic                 clock,
    input logic                 reset,
    multdiv_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // MULT: hi/lo/q1 form the Booth product register, m the multiplicand.
    // DIV:  hi is the partial remainder, lo the shifting quotient, m the divisor magnitude.
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   m;
    logic               q1;
    logic               sign;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    logic [WIDTH-1:0]   add_a_c;
    logic [WIDTH-1:0]   add_b_c;
    logic               add_cin_c;

    logic               start;
    logic               last_iter;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   mult_hi_nxt;
    logic [WIDTH-1:0]   mult_lo_nxt;
    logic [WIDTH-1:0]   div_s;
    logic [WIDTH-1:0]   div_r_nxt;
    logic [WIDTH-1:0]   div_q_nxt;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign a_abs     = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1)) : bus.data_operandA;
    assign b_abs     = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1)) : bus.data_operandB;

    // The shifted-in sign is the true 33rd bit of hi + add_b + cin, so the
    // multiplicand 0x80000000 (whose negation does not fit) still yields an exact product.
    assign mult_hi_nxt = {hi[WIDTH-1] ^ add_b_c[WIDTH-1] ^ bus.add_cout, bus.add_sum[WIDTH-1:1]};
    assign mult_lo_nxt = {bus.add_sum[0], lo[WIDTH-1:1]};

    // Remainder never exceeds the divisor magnitude, so its top bit is always zero and may be dropped.
    assign div_s     = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign div_r_nxt = bus.add_cout ? bus.add_sum : div_s;
    assign div_q_nxt = {lo[WIDTH-2:0], bus.add_cout};

    // Select the shared-adder operands for the current state; idle states drive zeros.
    always_comb begin
        add_a_c   = '0;
        add_b_c   = '0;
        add_cin_c = 1'b0;
        case (state)
            MULT: begin
                add_a_c = hi;
                case ({lo[0], q1})
                    2'b01: add_b_c = m;
                    2'b10: begin
                        add_b_c   = ~m;
                        add_cin_c = 1'b1;
                    end
                    default: add_b_c = '0;
                endcase
            end
            DIV: begin
                add_a_c   = div_s;
                add_b_c   = ~m;
                add_cin_c = 1'b1;
            end
            FIX: begin
                if (sign) begin
                    add_a_c   = ~lo;
                    add_cin_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.add_a          = add_a_c;
    assign bus.add_b          = add_b_c;
    assign bus.add_cin        = add_cin_c;
    assign bus.add_en         = (state == MULT) || (state == DIV) || (state == FIX);
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

    // Sequencer state machine with registered result, RDY and busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            q1       <= 1'b0;
            sign     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                cnt <= '0;
                if (bus.ctrl_MULT) begin
                    state  <= MULT;
                    hi     <= '0;
                    lo     <= bus.data_operandB;
                    q1     <= 1'b0;
                    m      <= bus.data_operandA;
                    busy_q <= 1'b1;
                end else if (bus.data_operandB == '0) begin
                    state    <= DONE;
                    busy_q   <= 1'b0;
                    result_q <= '0;
                    exc_q    <= 1'b1;
                end else begin
                    state  <= DIV;
                    hi     <= '0;
                    lo     <= a_abs;
                    m      <= b_abs;
                    sign   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                    busy_q <= 1'b1;
                end
            end else begin
                case (state)
                    MULT: begin
                        hi  <= mult_hi_nxt;
                        lo  <= mult_lo_nxt;
                        q1  <= lo[0];
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            state    <= DONE;
                            busy_q   <= 1'b0;
                            result_q <= mult_lo_nxt;
                            exc_q    <= (mult_hi_nxt != {WIDTH{mult_lo_nxt[WIDTH-1]}});
                        end
                    end
                    DIV: begin
                        hi  <= div_r_nxt;
                        lo  <= div_q_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        // Unsigned quotient magnitude of 2^31 is only representable when negated.
                        result_q <= sign ? bus.add_sum : lo;
                        exc_q    <= ~sign & lo[WIDTH-1];
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                    DONE: begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Purpose: self-checking bench for multdiv_sequencer with a behavioural adder and arithmetic reference model.
// Latency: checks RDY timing of 33 (MULT), 34 (DIV) and 1 (divide-by-zero) cycles after the start edge.
// Backpressure: none; exercises abort-by-restart and asynchronous reset mid-operation.
module tb_multdiv_sequencer;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    multdiv_sequencer_if #(.WIDTH(32)) bus ();

    multdiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Shared adder model.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'b0, bus.add_cin};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: exact 64-bit signed product; exception when it does not fit in 32 bits.
    function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        return {(p != longint'($signed(lo))), lo};
    endfunction

    // Reference: truncating signed division with divide-by-zero and overflow cases.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int q;
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Issues a start pulse (caller is just after a rising edge), then watches 40 cycles.
    task automatic run_op(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int npulse, output int en_cyc,
                          output logic [31:0] res, output logic exc);
        lat = -1; npulse = 0; en_cyc = 0; res = '0; exc = 1'b0;
        bus.ctrl_MULT = mul; bus.ctrl_DIV = dv;
        bus.data_operandA = a; bus.data_operandB = b;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom; bus.data_operandB = $urandom;
        if (bus.add_en) en_cyc++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (bus.add_en) en_cyc++;
            if (bus.data_resultRDY) begin
                npulse++;
                if (lat < 0) begin
                    lat = k; res = bus.data_result; exc = bus.data_exception;
                end
            end
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #5;
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", bus.data_resultRDY); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.add_en !== 1'b0) begin bad++; $display("FAIL reset_add_en got=%b exp=0", bus.add_en); end
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.data_result); end
        total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", bus.data_exception); end
        total++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 65'd0) begin bad++; $display("FAIL reset_add_ops got=%h/%h/%b exp=0", bus.add_a, bus.add_b, bus.add_cin); end
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_mult;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [32:0] e;
        logic [31:0] res;
        logic exc;
        int lat, np, en;
        ta[0] = 32'd7;          tb[0] = 32'hFFFF_FFFD;
        ta[1] = 32'h0001_0000;  tb[1] = 32'h0001_0000;
        ta[2] = 32'h8000_0000;  tb[2] = 32'hFFFF_FFFF;
        ta[3] = 32'hFFFF_FFFF;  tb[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            e = ref_mult(ta[i], tb[i]);
            run_op(1'b1, 1'b0, ta[i], tb[i], lat, np, en, res, exc);
            total++; if (lat != 33) begin bad++; $display("FAIL mult_lat[%0d] got=%0d exp=33", i, lat); end
            total++; if (np != 1) begin bad++; $display("FAIL mult_pulses[%0d] got=%0d exp=1", i, np); end
            total++; if (en != 32) begin bad++; $display("FAIL mult_en[%0d] got=%0d exp=32", i, en); end
            total++; if (res !== e[31:0]) begin bad++; $display("FAIL mult_res[%0d] got=%h exp=%h", i, res, e[31:0]); end
            total++; if (exc !== e[32]) begin bad++; $display("FAIL mult_exc[%0d] got=%b exp=%b", i, exc, e[32]); end
            total++; if (bus.data_result !== e[31:0]) begin bad++; $display("FAIL mult_hold[%0d] got=%h exp=%h", i, bus.data_result, e[31:0]); end
        end
    endtask

    task automatic test_div;
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [32:0] e;
        logic [31:0] res;
        logic exc;
        int lat, np, en, el, ee;
        ta[0] = 32'hFFFF_FF9C;  tb[0] = 32'd7;
        ta[1] = 32'd100;        tb[1] = 32'd7;
        ta[2] = 32'd5;          tb[2] = 32'd0;
        ta[3] = 32'h8000_0000;  tb[3] = 32'hFFFF_FFFF;
        ta[4] = 32'h8000_0000;  tb[4] = 32'd1;
        for (int i = 0; i < 5; i++) begin
            e  = ref_div(ta[i], tb[i]);
            el = (tb[i] == 32'd0) ? 1 : 34;
            ee = (tb[i] == 32'd0) ? 0 : 33;
            run_op(1'b0, 1'b1, ta[i], tb[i], lat, np, en, res, exc);
            total++; if (lat != el) begin bad++; $display("FAIL div_lat[%0d] got=%0d exp=%0d", i, lat, el); end
            total++; if (np != 1) begin bad++; $display("FAIL div_pulses[%0d] got=%0d exp=1", i, np); end
            total++; if (en != ee) begin bad++; $display("FAIL div_en[%0d] got=%0d exp=%0d", i, en, ee); end
            total++; if (res !== e[31:0]) begin bad++; $display("FAIL div_res[%0d] got=%h exp=%h", i, res, e[31:0]); end
            total++; if (exc !== e[32]) begin bad++; $display("FAIL div_exc[%0d] got=%b exp=%b", i, exc, e[32]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, res;
        logic [32:0] e;
        logic mul, exc;
        int lat, np, en, el;
        for (int i = 0; i < 24; i++) begin
            mul = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            e  = mul ? ref_mult(a, b) : ref_div(a, b);
            el = mul ? 33 : ((b == 32'd0) ? 1 : 34);
            run_op(mul, ~mul, a, b, lat, np, en, res, exc);
            total++; if (lat != el || np != 1) begin bad++; $display("FAIL rand_timing[%0d] got lat=%0d pulses=%0d exp lat=%0d pulses=1", i, lat, np, el); end
            total++; if ({exc, res} !== e) begin bad++; $display("FAIL rand_res[%0d] op=%0d a=%h b=%h got=%b/%h exp=%b/%h", i, mul, a, b, exc, res, e[32], e[31:0]); end
        end
    endtask

    task automatic test_abort;
        logic [31:0] res;
        logic exc;
        int lat, np, en, pre;
        pre = 0;
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd4;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) pre++;
        end
        run_op(1'b0, 1'b1, 32'd50, 32'd5, lat, np, en, res, exc);
        total++; if (pre + np != 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", pre + np); end
        total++; if (lat != 34) begin bad++; $display("FAIL abort_lat got=%0d exp=34", lat); end
        total++; if (res !== 32'd10 || exc !== 1'b0) begin bad++; $display("FAIL abort_res got=%h/%b exp=0000000a/0", res, exc); end
        run_op(1'b1, 1'b1, 32'd6, 32'd2, lat, np, en, res, exc);
        total++; if (lat != 33 || np != 1) begin bad++; $display("FAIL both_timing got lat=%0d pulses=%0d exp 33/1", lat, np); end
        total++; if (res !== 32'd12) begin bad++; $display("FAIL both_res got=%h exp=0000000c", res); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic exc;
        int lat, np, en;
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        repeat (20) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.add_en !== 1'b0) begin bad++; $display("FAIL rstmid_add_en got=%b exp=0", bus.add_en); end
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b exp=0", bus.data_resultRDY); end
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", bus.data_result); end
        @(posedge clock); #1 reset = 1'b1;
        run_op(1'b1, 1'b0, 32'd2, 32'd2, lat, np, en, res, exc);
        total++; if (lat != 33 || np != 1) begin bad++; $display("FAIL post_rst_timing got lat=%0d pulses=%0d exp 33/1", lat, np); end
        total++; if (res !== 32'd4 || exc !== 1'b0) begin bad++; $display("FAIL post_rst_res got=%h/%b exp=00000004/0", res, exc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
